morse_message_sequencer: RTL and testbench

- Queues up to DEPTH 3-bit letter codes and feeds them one at a time to the existing Morse transmitter through its Start and Letter inputs.
- Tracks each letter's completion by counting the transmitter's NewBitOut pulses, then inserts a configurable inter-letter gap measured in half-second ticks.
- Sits between the user or button logic and the transmitter.
- Shares ClockIn, Reset and the half-second tick (one RateDivider Enable) with the transmitter.

---
 rtl/morse_pkg.sv | 25 ++
 rtl/letter_fifo.sv | 91 +++++++++
 rtl/morse_message_sequencer.sv | 130 +++++++++++++
 tb/tb_morse_message_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse message sequencer.
//   LETTER_W     : width of a letter code
//   seq_state_t  : sequencer FSM states
//   A..H         : letter code constants
package morse_pkg;

    localparam int unsigned LETTER_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        SEND   = 2'd2,
        GAP    = 2'd3
    } seq_state_t;

    localparam logic [LETTER_W-1:0] A = 3'b000;
    localparam logic [LETTER_W-1:0] B = 3'b001;
    localparam logic [LETTER_W-1:0] C = 3'b010;
    localparam logic [LETTER_W-1:0] D = 3'b011;
    localparam logic [LETTER_W-1:0] E = 3'b100;
    localparam logic [LETTER_W-1:0] F = 3'b101;
    localparam logic [LETTER_W-1:0] G = 3'b110;
    localparam logic [LETTER_W-1:0] H = 3'b111;

endpackage

// File: rtl/letter_fifo.sv
// Letter FIFO with registered occupancy flags.
//   ClockIn, Reset : clock, asynchronous active-high reset
//   Push, DataIn   : enqueue request and letter
//   Pop            : dequeue the head (ignored when empty)
//   Flush          : clear all entries at the next edge
//   DataOut        : current head, combinational read
//   Count, Empty, Full : registered occupancy
//   DropOut        : one-cycle pulse after a Push was discarded for lack of room
module letter_fifo
    import morse_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       ClockIn,
    input  logic                       Reset,
    input  logic                       Push,
    input  logic                       Pop,
    input  logic                       Flush,
    input  logic [LETTER_W-1:0]        DataIn,
    output logic [LETTER_W-1:0]        DataOut,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       Empty,
    output logic                       Full,
    output logic                       DropOut
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [LETTER_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                empty_q, empty_d, full_q, full_d, drop_q, drop_d;
    logic                do_pop, do_push;

    // A pop in the same cycle frees a slot, so a Push into a full FIFO is still taken.
    assign do_pop  = Pop && !empty_q;
    assign do_push = Push && (!full_q || do_pop) && !Flush;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (Flush) begin
            // The head may still be popped this edge; everything else goes.
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_pop)  rptr_d = rptr_q + 1'b1;
            if (do_push) wptr_d = wptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
        drop_d  = Push && !Flush && full_q && !do_pop;
    end

    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge ClockIn) begin
        if (do_push) mem_q[wptr_q] <= DataIn;
    end

    assign DataOut = mem_q[rptr_q];
    assign Count   = count_q;
    assign Empty   = empty_q;
    assign Full    = full_q;
    assign DropOut = drop_q;

endmodule

// File: rtl/morse_message_sequencer.sv
// Queues letter codes and launches them one at a time into the Morse transmitter,
// waiting for the transmitter's bit pulses and then an inter-letter gap of ticks.
//   ClockIn, Reset : clock, asynchronous active-high reset
//   Push, LetterIn : enqueue request and letter code
//   Flush          : empty the queue (the letter being sent is unaffected)
//   TickIn         : half-second tick, counts the gap
//   NewBitIn       : transmitter NewBitOut, counts letter completion
//   StartOut, LetterOut : transmitter Start pulse and Letter code
//   Busy, Empty, Full, Count, DropOut : status
module morse_message_sequencer
    import morse_pkg::*;
#(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned BITS_PER_LETTER = 11,
    parameter int unsigned GAP_UNITS       = 3
) (
    input  logic                       ClockIn,
    input  logic                       Reset,
    input  logic                       Push,
    input  logic [LETTER_W-1:0]        LetterIn,
    input  logic                       Flush,
    input  logic                       TickIn,
    input  logic                       NewBitIn,
    output logic                       StartOut,
    output logic [LETTER_W-1:0]        LetterOut,
    output logic                       Busy,
    output logic                       Empty,
    output logic                       Full,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       DropOut
);

    localparam int unsigned CNT_MAX = (BITS_PER_LETTER > GAP_UNITS) ? BITS_PER_LETTER : GAP_UNITS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] BITS_INIT = CNT_W'(BITS_PER_LETTER);
    localparam logic [CNT_W-1:0] GAP_INIT  = CNT_W'(GAP_UNITS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    seq_state_t          state_q, state_d;
    logic [CNT_W-1:0]    bitcnt_q, bitcnt_d, gapcnt_q, gapcnt_d;
    logic                start_q, start_d;
    logic [LETTER_W-1:0] letter_q, letter_d;
    logic [LETTER_W-1:0] fifo_head;
    logic                pop, launch;

    letter_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .ClockIn (ClockIn),
        .Reset   (Reset),
        .Push    (Push),
        .Pop     (pop),
        .Flush   (Flush),
        .DataIn  (LetterIn),
        .DataOut (fifo_head),
        .Count   (Count),
        .Empty   (Empty),
        .Full    (Full),
        .DropOut (DropOut)
    );

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        gapcnt_d = gapcnt_q;
        letter_d = letter_q;
        start_d  = 1'b0;
        pop      = 1'b0;
        launch   = 1'b0;
        unique case (state_q)
            IDLE: launch = !Empty;
            LAUNCH: begin
                state_d  = SEND;
                bitcnt_d = BITS_INIT;
            end
            SEND: begin
                if (NewBitIn && bitcnt_q != '0) begin
                    bitcnt_d = bitcnt_q - 1'b1;
                    if (bitcnt_q == CNT_ONE) begin
                        if (GAP_UNITS == 0) begin
                            state_d = IDLE;
                            launch  = !Empty;
                        end else begin
                            state_d  = GAP;
                            gapcnt_d = GAP_INIT;
                        end
                    end
                end
            end
            GAP: begin
                if (TickIn && gapcnt_q != '0) begin
                    gapcnt_d = gapcnt_q - 1'b1;
                    if (gapcnt_q == CNT_ONE) begin
                        state_d = IDLE;
                        launch  = !Empty;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Any path that ends a letter (or idles) with work queued launches at this edge.
        if (launch) begin
            state_d  = LAUNCH;
            pop      = 1'b1;
            start_d  = 1'b1;
            letter_d = fifo_head;
        end
    end

    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            gapcnt_q <= '0;
            start_q  <= 1'b0;
            letter_q <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            gapcnt_q <= gapcnt_d;
            start_q  <= start_d;
            letter_q <= letter_d;
        end
    end

    assign StartOut  = start_q;
    assign LetterOut = letter_q;
    assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_morse_message_sequencer.sv
// Self-checking bench for morse_message_sequencer: a directed vector table, a
// randomized run against a queue-based reference model, and hand-written corner cases.
module tb_morse_message_sequencer;
    import morse_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned BITS  = 11;
    localparam int unsigned GAPS  = 3;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          ClockIn = 1'b0;
    logic          Reset, Push, Flush, TickIn, NewBitIn;
    logic [2:0]    LetterIn;
    logic          StartOut, Busy, Empty, Full, DropOut;
    logic [2:0]    LetterOut;
    logic [CW-1:0] Count;
    logic          z_start, z_busy, z_empty, z_full, z_drop;
    logic [2:0]    z_letter;
    logic [CW-1:0] z_count;

    morse_message_sequencer #(
        .DEPTH (DEPTH), .BITS_PER_LETTER (BITS), .GAP_UNITS (GAPS)
    ) dut (
        .ClockIn (ClockIn), .Reset (Reset), .Push (Push), .LetterIn (LetterIn),
        .Flush (Flush), .TickIn (TickIn), .NewBitIn (NewBitIn),
        .StartOut (StartOut), .LetterOut (LetterOut), .Busy (Busy), .Empty (Empty),
        .Full (Full), .Count (Count), .DropOut (DropOut)
    );

    morse_message_sequencer #(
        .DEPTH (DEPTH), .BITS_PER_LETTER (BITS), .GAP_UNITS (0)
    ) dut_nogap (
        .ClockIn (ClockIn), .Reset (Reset), .Push (Push), .LetterIn (LetterIn),
        .Flush (Flush), .TickIn (TickIn), .NewBitIn (NewBitIn),
        .StartOut (z_start), .LetterOut (z_letter), .Busy (z_busy), .Empty (z_empty),
        .Full (z_full), .Count (z_count), .DropOut (z_drop)
    );

    always #5 ClockIn = ~ClockIn;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge ClockIn);
        #1;
    endtask

    task automatic drive(input logic p, input logic [2:0] l, input logic f, input logic t,
                         input logic n);
        Push = p; LetterIn = l; Flush = f; TickIn = t; NewBitIn = n;
    endtask

    task automatic do_reset();
        drive(0, 3'b000, 0, 0, 0);
        Reset = 1'b1;
        repeat (2) step();
        Reset = 1'b0;
    endtask

    // Reference model: a queue of letters plus "letters-in-flight" bookkeeping in
    // plain counts of remaining bits and remaining gap ticks.
    logic [2:0] m_q[$];
    bit         m_launch, m_start, m_drop;
    int         m_bits, m_gap;
    logic [2:0] m_letter;

    task automatic model_reset();
        m_q.delete();
        m_launch = 0; m_start = 0; m_drop = 0;
        m_bits = 0; m_gap = 0; m_letter = 3'b000;
    endtask

    task automatic model_step();
        bit can, go, full;
        can = (m_q.size() > 0);
        go  = 0;
        if (m_launch) begin
            m_launch = 0;
            m_bits   = BITS;
        end else if (m_bits > 0) begin
            if (NewBitIn) begin
                m_bits--;
                if (m_bits == 0) m_gap = GAPS;
                if (m_bits == 0 && GAPS == 0) go = can;
            end
        end else if (m_gap > 0) begin
            if (TickIn) begin
                m_gap--;
                if (m_gap == 0) go = can;
            end
        end else begin
            go = can;
        end
        full   = (m_q.size() == DEPTH);
        m_drop = Push && !Flush && full && !go;
        if (go) m_letter = m_q.pop_front();
        if (Flush) m_q.delete();
        else if (Push && (!full || go)) m_q.push_back(LetterIn);
        m_launch = go;
        m_start  = go;
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".start"},  int'(StartOut),  int'(m_start));
        check({tag, ".letter"}, int'(LetterOut), int'(m_letter));
        check({tag, ".busy"},   int'(Busy),      int'(m_launch || m_bits > 0 || m_gap > 0));
        check({tag, ".count"},  int'(Count),     m_q.size());
        check({tag, ".empty"},  int'(Empty),     int'(m_q.size() == 0));
        check({tag, ".full"},   int'(Full),      int'(m_q.size() == DEPTH));
        check({tag, ".drop"},   int'(DropOut),   int'(m_drop));
    endtask

    typedef struct {
        logic       push;
        logic [2:0] letter;
        logic       flush, tick, newbit;
        logic       exp_start;
        logic [2:0] exp_letter;
        logic       exp_busy;
        int         exp_count;
        logic       exp_drop;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int starts;

        //          push letter  fl tk nb   start letter busy cnt drop
        vecs[0]  = '{1, 3'b101, 0, 0, 0,  0, 3'b000, 0, 1, 0};
        vecs[1]  = '{0, 3'b000, 0, 0, 0,  1, 3'b101, 1, 0, 0};
        vecs[2]  = '{1, 3'b010, 0, 0, 0,  0, 3'b101, 1, 1, 0};
        vecs[3]  = '{0, 3'b000, 0, 0, 1,  0, 3'b101, 1, 1, 0};
        vecs[4]  = '{1, 3'b011, 0, 0, 0,  0, 3'b101, 1, 2, 0};
        vecs[5]  = '{0, 3'b000, 1, 0, 0,  0, 3'b101, 1, 0, 0};
        vecs[6]  = '{1, 3'b111, 1, 0, 0,  0, 3'b101, 1, 0, 0};
        vecs[7]  = '{1, 3'b000, 0, 0, 0,  0, 3'b101, 1, 1, 0};
        vecs[8]  = '{1, 3'b001, 0, 0, 0,  0, 3'b101, 1, 2, 0};
        vecs[9]  = '{1, 3'b010, 0, 0, 0,  0, 3'b101, 1, 3, 0};
        vecs[10] = '{1, 3'b011, 0, 1, 0,  0, 3'b101, 1, 4, 0};
        vecs[11] = '{1, 3'b111, 0, 0, 0,  0, 3'b101, 1, 4, 1};
        vecs[12] = '{0, 3'b000, 0, 0, 0,  0, 3'b101, 1, 4, 0};

        // Reset state
        drive(0, 3'b000, 0, 0, 0);
        Reset = 1'b1;
        #3;
        check("rst.start", StartOut, 0);
        check("rst.letter", LetterOut, 0);
        check("rst.busy", Busy, 0);
        check("rst.empty", Empty, 1);
        check("rst.full", Full, 0);
        check("rst.count", Count, 0);
        check("rst.drop", DropOut, 0);
        do_reset();

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].push, vecs[i].letter, vecs[i].flush, vecs[i].tick, vecs[i].newbit);
            step();
            check($sformatf("vec%0d.start", i),  StartOut,  vecs[i].exp_start);
            check($sformatf("vec%0d.letter", i), LetterOut, vecs[i].exp_letter);
            check($sformatf("vec%0d.busy", i),   Busy,      vecs[i].exp_busy);
            check($sformatf("vec%0d.count", i),  Count,     vecs[i].exp_count);
            check($sformatf("vec%0d.drop", i),   DropOut,   vecs[i].exp_drop);
        end

        // Randomized run against the reference model
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) < 35, 3'($urandom), $urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 45);
            step();
            model_step();
            compare_model("rnd");
        end

        // Asynchronous reset mid-SEND after 5 bits with two letters queued
        do_reset();
        drive(1, 3'b110, 0, 0, 0); step();
        drive(1, 3'b001, 0, 0, 0); step();
        drive(1, 3'b010, 0, 0, 0); step();
        drive(0, 3'b000, 0, 0, 1);
        repeat (5) step();
        drive(0, 3'b000, 0, 0, 0);
        check("arst.pre_count", Count, 2);
        check("arst.pre_busy", Busy, 1);
        #2 Reset = 1'b1;
        #1;
        check("arst.start", StartOut, 0);
        check("arst.busy", Busy, 0);
        check("arst.count", Count, 0);
        check("arst.letter", LetterOut, 0);
        step();
        Reset = 1'b0;
        starts = 0;
        drive(0, 3'b000, 0, 1, 1);
        for (int i = 0; i < 20; i++) begin
            step();
            if (StartOut) starts++;
        end
        check("arst.no_resume", starts, 0);

        // No-gap build: next launch directly after the 11th bit; Flush spares the current letter
        do_reset();
        drive(1, 3'b001, 0, 0, 0); step();
        drive(1, 3'b010, 0, 0, 0); step();
        check("nogap.first_start", z_start, 1);
        check("nogap.first_letter", z_letter, 3'b001);
        drive(0, 3'b000, 0, 0, 0); step();
        drive(0, 3'b000, 0, 0, 1);
        for (int i = 0; i < 10; i++) step();
        check("nogap.start_before_last", z_start, 0);
        step();
        check("nogap.second_start", z_start, 1);
        check("nogap.second_letter", z_letter, 3'b010);
        drive(0, 3'b000, 0, 0, 0); step();
        check("nogap.start_one_cycle", z_start, 0);
        drive(1, 3'b011, 0, 0, 0); step();
        drive(0, 3'b000, 1, 0, 0); step();
        check("nogap.flush_count", z_count, 0);
        check("nogap.flush_busy", z_busy, 1);
        starts = 0;
        drive(0, 3'b000, 0, 0, 1);
        for (int i = 0; i < 11; i++) begin
            step();
            if (z_start) starts++;
        end
        drive(0, 3'b000, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            if (z_start) starts++;
        end
        check("nogap.no_more_starts", starts, 0);
        check("nogap.idle_after", z_busy, 0);
        check("nogap.letter_held", z_letter, 3'b010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
